// File: rtl/matrix_operand_loader_pkg.sv
// loader_pkg: state encoding, sizing helpers and default operand geometry shared with the multiplier core.
package loader_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DIM = 3;
    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, FULL} state_t;
    function automatic int elems(input int dim);
        return dim * dim;
    endfunction
    function automatic int idx_w(input int dim);
        return $clog2(dim * dim);
    endfunction
endpackage

// File: rtl/matrix_operand_loader_if.sv
// matrix_operand_loader_if: control, element stream and parallel operand bus of the loader.
interface matrix_operand_loader_if #(
    parameter int DATA_W = 8,
    parameter int DIM = 3
);
    logic enable;
    logic start;
    logic reuse_a;
    logic clear;
    logic [DATA_W-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic consume;
    logic [DIM*DIM*DATA_W-1:0] out_a;
    logic [DIM*DIM*DATA_W-1:0] out_b;
    logic a_valid;
    logic busy;
    logic done;
    modport slave (
        input enable, start, reuse_a, clear, in_data, in_valid, consume,
        output in_ready, out_a, out_b, a_valid, busy, done
    );
    modport master (
        output enable, start, reuse_a, clear, in_data, in_valid, consume,
        input in_ready, out_a, out_b, a_valid, busy, done
    );
endinterface

// File: rtl/matrix_operand_loader_operand_bank.sv
// operand_bank: N x DATA_W register file with indexed write and a flattened row-major read port.
module operand_bank #(
    parameter int DATA_W = 8,
    parameter int N = 9,
    parameter int IW = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_we,
    input  logic [IW-1:0] i_idx,
    input  logic [DATA_W-1:0] i_data,
    output logic [N*DATA_W-1:0] o_flat
);
    logic [DATA_W-1:0] r_mem [N];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) r_mem[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) if (i_we && i_idx == IW'(k)) r_mem[k] <= i_data;
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_out
        assign o_flat[g*DATA_W +: DATA_W] = r_mem[g];
    end
endmodule

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: fills operand matrices A then B from a valid/ready element stream,
// optionally reusing A, and holds them with done until the core consumes them.
module matrix_operand_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIM = DEF_DIM
) (
    input logic clk,
    input logic reset,
    matrix_operand_loader_if.slave bus
);
    localparam int N = elems(DIM);
    localparam int IW = idx_w(DIM);
    state_t r_state;
    logic [IW-1:0] r_idx;
    logic r_a_valid;
    logic r_done;
    logic w_busy;
    logic w_ready;
    logic w_beat;
    logic w_last;
    state_t w_load_state;
    assign w_busy = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign w_ready = bus.enable && w_busy;
    assign w_beat = bus.in_valid && w_ready;
    assign w_last = r_idx == IW'(N - 1);
    // Reuse only when A is actually complete; otherwise fall back to a full load.
    assign w_load_state = (bus.reuse_a && r_a_valid) ? LOAD_B : LOAD_A;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx <= '0;
            r_a_valid <= 1'b0;
            r_done <= 1'b0;
        end else if (bus.clear) begin
            r_state <= IDLE;
            r_idx <= '0;
            r_done <= 1'b0;
            if (r_state == LOAD_A) r_a_valid <= 1'b0;
        end else if (bus.enable) begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= w_load_state;
                    r_idx <= '0;
                    r_a_valid <= r_a_valid && bus.reuse_a;
                end
                LOAD_A: if (w_beat) begin
                    r_state <= w_last ? LOAD_B : LOAD_A;
                    r_idx <= w_last ? '0 : r_idx + IW'(1);
                    r_a_valid <= w_last;
                end
                LOAD_B: if (w_beat) begin
                    r_state <= w_last ? FULL : LOAD_B;
                    r_idx <= w_last ? '0 : r_idx + IW'(1);
                    r_done <= w_last;
                end
                FULL: if (bus.consume) begin
                    r_state <= bus.start ? w_load_state : IDLE;
                    r_idx <= '0;
                    r_done <= 1'b0;
                    r_a_valid <= r_a_valid && (bus.reuse_a || !bus.start);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready = w_ready;
    assign bus.busy = w_busy;
    assign bus.a_valid = r_a_valid;
    assign bus.done = r_done;
    operand_bank #(.DATA_W(DATA_W), .N(N), .IW(IW)) u_bank_a (
        .clk(clk),
        .reset(reset),
        .i_we(w_beat && !bus.clear && r_state == LOAD_A),
        .i_idx(r_idx),
        .i_data(bus.in_data),
        .o_flat(bus.out_a)
    );
    operand_bank #(.DATA_W(DATA_W), .N(N), .IW(IW)) u_bank_b (
        .clk(clk),
        .reset(reset),
        .i_we(w_beat && !bus.clear && r_state == LOAD_B),
        .i_idx(r_idx),
        .i_data(bus.in_data),
        .o_flat(bus.out_b)
    );
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: directed and random stimulus against a beat-counting model of the loader.
module tb_matrix_operand_loader;
    localparam int W = 8;
    localparam int D = 3;
    localparam int N = D * D;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    matrix_operand_loader_if #(.DATA_W(W), .DIM(D)) bus();
    matrix_operand_loader #(.DATA_W(W), .DIM(D)) dut (.clk(clk), .reset(reset), .bus(bus));
    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] ma [N];
    logic [W-1:0] mb [N];
    logic m_av;
    logic m_done;
    int need_a;
    int need_b;
    logic last_beat;
    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            ma[k] = '0;
            mb[k] = '0;
        end
        m_av = 1'b0;
        m_done = 1'b0;
        need_a = 0;
        need_b = 0;
    endtask
    task automatic begin_load(input logic ru);
        if (ru && m_av) need_b = N;
        else begin
            m_av = 1'b0;
            need_a = N;
            need_b = N;
        end
    endtask
    task automatic check_outputs(input string tag);
        logic [N*W-1:0] fa, fb;
        for (int k = 0; k < N; k++) begin
            fa[k*W +: W] = ma[k];
            fb[k*W +: W] = mb[k];
        end
        chk({tag, ".a_valid"}, bus.a_valid, m_av);
        chk({tag, ".done"}, bus.done, m_done);
        chk({tag, ".busy"}, bus.busy, (need_a + need_b) > 0);
        chk({tag, ".out_a"}, bus.out_a, fa);
        chk({tag, ".out_b"}, bus.out_b, fb);
    endtask
    task automatic cyc(input logic en, input logic vld, input logic [W-1:0] d, input logic st,
                       input logic ru, input logic cl, input logic co);
        logic busy;
        bus.enable = en;
        bus.in_valid = vld;
        bus.in_data = d;
        bus.start = st;
        bus.reuse_a = ru;
        bus.clear = cl;
        bus.consume = co;
        #1;
        busy = (need_a + need_b) > 0;
        chk("in_ready", bus.in_ready, en && busy);
        @(posedge clk);
        #1;
        last_beat = 1'b0;
        if (cl) begin
            if (need_a > 0) m_av = 1'b0;
            need_a = 0;
            need_b = 0;
            m_done = 1'b0;
        end else if (en) begin
            if (busy) begin
                if (vld) begin
                    last_beat = 1'b1;
                    if (need_a > 0) begin
                        ma[N-need_a] = d;
                        need_a--;
                        if (need_a == 0) m_av = 1'b1;
                    end else begin
                        mb[N-need_b] = d;
                        need_b--;
                        if (need_b == 0) m_done = 1'b1;
                    end
                end
            end else if (m_done) begin
                if (co) begin
                    m_done = 1'b0;
                    if (st) begin_load(ru);
                end
            end else if (st) begin_load(ru);
        end
        check_outputs("cyc");
    endtask
    task automatic feed(input int n, input int base, input bit gaps);
        int sent = 0;
        int c = 0;
        while (sent < n && c < 200) begin
            cyc(gaps ? !(c >= 5 && c < 8) : 1'b1, gaps ? (c % 2 == 0) : 1'b1, W'(base + sent), 0, 0, 0, 0);
            if (last_beat) sent++;
            c++;
        end
        n_chk++;
        assert (sent == n) n_pass++;
        else $error("FAIL feed_beats observed=%0d expected=%0d", sent, n);
    endtask
    initial begin
        bus.enable = 1'b0;
        bus.start = 1'b0;
        bus.reuse_a = 1'b0;
        bus.clear = 1'b0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.consume = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset.in_ready", bus.in_ready, 1'b0);
        check_outputs("reset");
        reset = 1'b0;
        cyc(1, 0, 0, 1, 0, 0, 0);
        feed(2 * N, 1, 0);
        cyc(1, 1, 8'h55, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 0, 0);
        feed(N, 8'hF0, 0);
        cyc(1, 0, 0, 1, 0, 0, 1);
        feed(2 * N, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs("reset2");
        reset = 1'b0;
        cyc(1, 0, 0, 1, 1, 0, 0);
        feed(4, 8'h30, 0);
        cyc(1, 1, 8'h77, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        feed(2 * N, 8'h40, 0);
        cyc(1, 0, 0, 1, 0, 0, 1);
        feed(N + 3, 8'h60, 0);
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst.in_ready", bus.in_ready, 1'b0);
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("async_rst_hold");
        reset = 1'b0;
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), W'($urandom),
                $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0,
                $urandom_range(0, 2) == 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
